// File: rtl/uart_pkg.sv
// Shared definitions for the UART command master: parity modes, FSM states,
// read error codes and frame-length / parity helpers.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_PARITY  = 2'd1,
      ERR_FRAMING = 2'd2,
      ERR_TIMEOUT = 2'd3
   } rd_err_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_TX_START,
      ST_TX_DATA,
      ST_TX_PAR,
      ST_TX_STOP,
      ST_TX_GAP,
      ST_RX_WAIT,
      ST_RX_START,
      ST_RX_DATA,
      ST_RX_PAR,
      ST_RX_STOP
   } state_t;

   // Bit-times in one frame: start + payload + optional parity + stop bits.
   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

   // Payloads are at most 8 bits; zero-extension does not change the XOR.
   function automatic logic calc_parity(input logic [7:0] data, input int mode);
      return (mode == PAR_ODD) ? ~^data : ^data;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter shared by the tx and rx paths; produces mid-bit and
// end-of-bit strobes.
module uart_bit_timer #(
   parameter int CLK_DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic restart,
   input  logic resync,
   output logic bit_mid,
   output logic bit_end
);

   localparam int            CW        = $clog2(CLK_DIV);
   localparam logic [CW-1:0] LOAD_FULL = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] LOAD_LATE = CW'(CLK_DIV - 2);
   localparam logic [CW-1:0] MID_CNT   = CW'(CLK_DIV - 1 - CLK_DIV / 2);

   logic [CW-1:0] cnt;

   // restart: the next cycle is the first of a bit.
   // resync: the current cycle already is the first of a bit (rx edge detect).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= LOAD_FULL;
      end else if (resync) begin
         cnt <= LOAD_LATE;
      end else if (cnt == '0) begin
         cnt <= LOAD_FULL;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign bit_mid = (cnt == MID_CNT);
   assign bit_end = (cnt == '0);

endmodule

// File: rtl/uart_cmd_master.sv
// UART command master: serialises read/write command words on tx and, for
// reads, collects the slave's response frame from rx with timeout.
module uart_cmd_master
   import uart_pkg::*;
#(
   parameter int CLK_DIV      = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 1,
   parameter int STOP_BITS    = 1,
   parameter int GAP_BITS     = 1,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2*DATA_BITS-1:0] cmd_in,
   input  logic                   cmd_vld,
   output logic                   cmd_rdy,
   output logic                   tx,
   input  logic                   rx,
   output logic                   wr_done,
   output logic                   read_vld,
   output logic [DATA_BITS-1:0]   read_data,
   output logic [1:0]             read_err
);

   localparam int W       = DATA_BITS;
   localparam int MAX_A   = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
   localparam int MAX_B   = (GAP_BITS > TIMEOUT_BITS) ? GAP_BITS : TIMEOUT_BITS;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_BITS - 1);
   localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_BITS - 1);

   state_t          state, state_next;
   logic [CW-1:0]   bit_cnt, bit_cnt_next;
   logic            frame_sel, frame_sel_next;
   logic [2*W-1:0]  cmd_q, cmd_next;
   logic [W-1:0]    tx_shift, tx_shift_next;
   logic [W-1:0]    rx_shift, rx_shift_next;
   logic            rx_par, rx_par_next;
   logic            tx_next;
   logic            wr_done_next, read_vld_next;
   logic [W-1:0]    read_data_next;
   logic [1:0]      read_err_next;
   logic            restart, resync;
   logic            bit_mid, bit_end;
   logic            rx_meta, rx_s, rx_prev;
   logic            rx_fall, accept, is_read;
   logic [W-1:0]    frame_byte;
   logic            tx_par, rx_par_err;

   // rx is asynchronous: two flops for metastability, a third for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign rx_fall    = rx_prev & ~rx_s;
   assign accept     = cmd_vld & cmd_rdy;
   assign is_read    = cmd_q[2*W-1];
   assign frame_byte = frame_sel ? cmd_q[W-1:0] : cmd_q[2*W-1:W];
   assign tx_par     = calc_parity(8'(frame_byte), PARITY);
   assign rx_par_err = (PARITY != PAR_NONE) && (rx_par != calc_parity(8'(rx_shift), PARITY));

   uart_bit_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .resync  (resync),
      .bit_mid (bit_mid),
      .bit_end (bit_end)
   );

   // Next-state logic. bit_cnt is reused as data, stop, gap and timeout counter;
   // it is left alone in RX_START so a false start does not reset the timeout.
   always_comb begin
      state_next     = state;
      bit_cnt_next   = bit_cnt;
      frame_sel_next = frame_sel;
      cmd_next       = cmd_q;
      tx_shift_next  = tx_shift;
      rx_shift_next  = rx_shift;
      rx_par_next    = rx_par;
      wr_done_next   = 1'b0;
      read_vld_next  = 1'b0;
      read_data_next = read_data;
      read_err_next  = read_err;
      restart        = 1'b0;
      resync         = 1'b0;
      tx_next        = 1'b1;

      case (state)
         ST_IDLE: begin
            restart = 1'b1;
            if (accept) begin
               state_next     = ST_TX_START;
               cmd_next       = cmd_in;
               frame_sel_next = 1'b0;
               bit_cnt_next   = '0;
            end
         end
         ST_TX_START: begin
            if (bit_end) begin
               state_next    = ST_TX_DATA;
               tx_shift_next = frame_byte;
               bit_cnt_next  = '0;
            end
         end
         ST_TX_DATA: begin
            if (bit_end) begin
               if (bit_cnt == DATA_LAST) begin
                  bit_cnt_next = '0;
                  state_next   = (PARITY != PAR_NONE) ? ST_TX_PAR : ST_TX_STOP;
               end else begin
                  bit_cnt_next  = bit_cnt + 1'b1;
                  tx_shift_next = tx_shift >> 1;
               end
            end
         end
         ST_TX_PAR: begin
            if (bit_end) begin
               state_next   = ST_TX_STOP;
               bit_cnt_next = '0;
            end
         end
         ST_TX_STOP: begin
            if (bit_end) begin
               if (bit_cnt == STOP_LAST) begin
                  bit_cnt_next = '0;
                  if (is_read) begin
                     state_next = ST_RX_WAIT;
                  end else if (frame_sel) begin
                     state_next   = ST_IDLE;
                     wr_done_next = 1'b1;
                  end else begin
                     frame_sel_next = 1'b1;
                     state_next     = (GAP_BITS > 0) ? ST_TX_GAP : ST_TX_START;
                  end
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end
         end
         ST_TX_GAP: begin
            if (bit_end) begin
               if (bit_cnt == GAP_LAST) begin
                  state_next   = ST_TX_START;
                  bit_cnt_next = '0;
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end
         end
         ST_RX_WAIT: begin
            if (rx_fall) begin
               state_next = ST_RX_START;
               resync     = 1'b1;
            end else if (bit_end) begin
               if (bit_cnt == TMO_LAST) begin
                  state_next    = ST_IDLE;
                  read_vld_next = 1'b1;
                  read_err_next = ERR_TIMEOUT;
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end
         end
         ST_RX_START: begin
            if (bit_mid && rx_s) begin
               state_next = ST_RX_WAIT;
            end else if (bit_end) begin
               state_next   = ST_RX_DATA;
               bit_cnt_next = '0;
            end
         end
         ST_RX_DATA: begin
            if (bit_mid) begin
               rx_shift_next = {rx_s, rx_shift[W-1:1]};
            end
            if (bit_end) begin
               if (bit_cnt == DATA_LAST) begin
                  bit_cnt_next = '0;
                  state_next   = (PARITY != PAR_NONE) ? ST_RX_PAR : ST_RX_STOP;
               end else begin
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end
         end
         ST_RX_PAR: begin
            if (bit_mid) begin
               rx_par_next = rx_s;
            end
            if (bit_end) begin
               state_next = ST_RX_STOP;
            end
         end
         ST_RX_STOP: begin
            if (bit_mid) begin
               state_next     = ST_IDLE;
               read_vld_next  = 1'b1;
               read_data_next = rx_shift;
               if (!rx_s) begin
                  read_err_next = ERR_FRAMING;
               end else if (rx_par_err) begin
                  read_err_next = ERR_PARITY;
               end else begin
                  read_err_next = ERR_OK;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      // tx is registered, so it is driven from where the FSM is going.
      case (state_next)
         ST_TX_START: tx_next = 1'b0;
         ST_TX_DATA:  tx_next = tx_shift_next[0];
         ST_TX_PAR:   tx_next = tx_par;
         default:     tx_next = 1'b1;
      endcase
   end

   // cmd_rdy rises one cycle after the FSM settles back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         frame_sel <= 1'b0;
         cmd_q     <= '0;
         tx_shift  <= '0;
         rx_shift  <= '0;
         rx_par    <= 1'b0;
         tx        <= 1'b1;
         cmd_rdy   <= 1'b1;
         wr_done   <= 1'b0;
         read_vld  <= 1'b0;
         read_data <= '0;
         read_err  <= ERR_OK;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         frame_sel <= frame_sel_next;
         cmd_q     <= cmd_next;
         tx_shift  <= tx_shift_next;
         rx_shift  <= rx_shift_next;
         rx_par    <= rx_par_next;
         tx        <= tx_next;
         cmd_rdy   <= (state == ST_IDLE) && (state_next == ST_IDLE);
         wr_done   <= wr_done_next;
         read_vld  <= read_vld_next;
         read_data <= read_data_next;
         read_err  <= read_err_next;
      end
   end

endmodule

// File: tb/tb_uart_cmd_master.sv
// Scoreboard bench for uart_cmd_master: stimulus pushes expected tx bits and
// completion events; a monitor pops and compares them as the DUT produces them.
module tb_uart_cmd_master;

   localparam int CLK_DIV      = 4;
   localparam int DATA_BITS    = 8;
   localparam int PARITY       = 1;
   localparam int STOP_BITS    = 1;
   localparam int GAP_BITS     = 1;
   localparam int TIMEOUT_BITS = 32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cmd_in = 16'h0;
   logic        cmd_vld = 1'b0;
   logic        cmd_rdy;
   logic        tx;
   logic        rx = 1'b1;
   logic        wr_done;
   logic        read_vld;
   logic [7:0]  read_data;
   logic [1:0]  read_err;

   int checks = 0;
   int errors = 0;
   int unexpected = 0;
   int cyc = 0;

   typedef struct {
      bit         is_read;
      logic [7:0] data;
      logic [1:0] err;
      int         cyc;
   } ev_t;

   typedef struct {
      int   cyc;
      logic val;
   } txe_t;

   ev_t  evq[$];
   txe_t txq[$];
   ev_t  mon_e;
   txe_t mon_t;

   uart_cmd_master #(
      .CLK_DIV      (CLK_DIV),
      .DATA_BITS    (DATA_BITS),
      .PARITY       (PARITY),
      .STOP_BITS    (STOP_BITS),
      .GAP_BITS     (GAP_BITS),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_in    (cmd_in),
      .cmd_vld   (cmd_vld),
      .cmd_rdy   (cmd_rdy),
      .tx        (tx),
      .rx        (rx),
      .wr_done   (wr_done),
      .read_vld  (read_vld),
      .read_data (read_data),
      .read_err  (read_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, actual, required);
      end
   endtask

   // Expected tx level at mid-bit for start, LSB-first payload, even parity, stop.
   function automatic void push_frame(input logic [7:0] b, input int start);
      logic [10:0] bits;
      txe_t        t;
      bits = {1'b1, ^b, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         t.cyc = start + i * CLK_DIV + CLK_DIV / 2;
         t.val = bits[i];
         txq.push_back(t);
      end
   endfunction

   function automatic void push_event(input bit is_read, input logic [7:0] data,
                                      input logic [1:0] err, input int c);
      ev_t e;
      e.is_read = is_read;
      e.data    = data;
      e.err     = err;
      e.cyc     = c;
      evq.push_back(e);
   endfunction

   // Monitor: compares tx at scheduled mid-bit cycles and every completion pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (txq.size() > 0 && txq[0].cyc == cyc) begin
            mon_t = txq.pop_front();
            checkOutput("tx_bit", {31'b0, tx}, {31'b0, mon_t.val});
         end
         if (wr_done && read_vld) begin
            checkOutput("done_and_vld_together", 32'd1, 32'd0);
         end
         if (wr_done || read_vld) begin
            if (evq.size() == 0) begin
               unexpected++;
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_event at cycle %0d: got wr_done=%0b read_vld=%0b, want none",
                        cyc, wr_done, read_vld);
            end else begin
               mon_e = evq.pop_front();
               checkOutput("event_kind", {31'b0, read_vld}, {31'b0, mon_e.is_read});
               if (mon_e.is_read) begin
                  checkOutput("read_data", {24'b0, read_data}, {24'b0, mon_e.data});
                  checkOutput("read_err", {30'b0, read_err}, {30'b0, mon_e.err});
               end
               if (mon_e.cyc >= 0) begin
                  checkOutput("event_cycle", cyc, mon_e.cyc);
               end
            end
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Issues one command at a negedge; acc is the accept cycle (cycle 0).
   task automatic applyStimulus(input logic [15:0] cmd, output int acc);
      int n;
      n = 0;
      while (!cmd_rdy && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_rdy) checkOutput("cmd_rdy_wait", {31'b0, cmd_rdy}, 32'd1);
      cmd_in  = cmd;
      cmd_vld = 1'b1;
      acc     = cyc;
      push_frame(cmd[15:8], acc + 1);
      if (!cmd[15]) begin
         mon_t.cyc = acc + 1 + 44 + 2;
         mon_t.val = 1'b1;
         txq.push_back(mon_t);
         push_frame(cmd[7:0], acc + 1 + 48);
         push_event(1'b0, 8'h00, 2'd0, acc + 93);
      end
      @(negedge clk);
      cmd_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((evq.size() > 0 || txq.size() > 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (evq.size() > 0 || txq.size() > 0) begin
         checkOutput("pending_expectations", evq.size() + txq.size(), 32'd0);
         evq.delete();
         txq.delete();
      end
   endtask

   task automatic send_rx(input logic [7:0] data, input logic par, input logic stop);
      logic [10:0] bits;
      bits = {stop, par, data, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx = bits[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   // Read 0x8A00; the reply starts 3 bit-times after RX_WAIT entry (cycle 45).
   task automatic do_read(input logic [7:0] data, input logic par, input logic stop, input logic [1:0] err);
      int acc;
      applyStimulus(16'h8A00, acc);
      push_event(1'b1, data, err, -1);
      wait_until(acc + 57);
      send_rx(data, par, stop);
      wait_idle();
   endtask

   initial begin
      int acc;
      int unexp0;

      repeat (3) @(negedge clk);
      checkOutput("rst_tx", {31'b0, tx}, 32'd1);
      checkOutput("rst_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
      checkOutput("rst_wr_done", {31'b0, wr_done}, 32'd0);
      checkOutput("rst_read_vld", {31'b0, read_vld}, 32'd0);
      checkOutput("rst_read_data", {24'b0, read_data}, 32'h0);
      checkOutput("rst_read_err", {30'b0, read_err}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] write 0x12A5");
      applyStimulus(16'h12A5, acc);
      checkOutput("cmd_rdy_busy", {31'b0, cmd_rdy}, 32'd0);
      wait_until(acc + 93);
      checkOutput("cmd_rdy_at_done", {31'b0, cmd_rdy}, 32'd0);
      wait_until(acc + 94);
      checkOutput("cmd_rdy_after_done", {31'b0, cmd_rdy}, 32'd1);
      wait_idle();

      $display("[TB] reads: ok, parity error, framing error");
      do_read(8'h3C, 1'b0, 1'b1, 2'd0);
      do_read(8'h3C, 1'b1, 1'b1, 2'd1);
      do_read(8'h3C, 1'b0, 1'b0, 2'd2);

      $display("[TB] read with rx glitch then reply 0xA7");
      applyStimulus(16'h8A00, acc);
      push_event(1'b1, 8'hA7, 2'd0, -1);
      wait_until(acc + 49);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      wait_until(acc + 57);
      send_rx(8'hA7, 1'b1, 1'b1);
      wait_idle();

      $display("[TB] read timeout");
      applyStimulus(16'h8500, acc);
      push_event(1'b1, 8'hA7, 2'd3, acc + 45 + 128);
      wait_idle();

      $display("[TB] reset during write");
      applyStimulus(16'h12A5, acc);
      wait_until(acc + 14);
      checkOutput("pre_reset_tx", {31'b0, tx}, 32'd0);
      #2;
      rst_n = 1'b0;
      evq.delete();
      txq.delete();
      #1;
      checkOutput("abort_tx", {31'b0, tx}, 32'd1);
      checkOutput("abort_cmd_rdy", {31'b0, cmd_rdy}, 32'd1);
      checkOutput("abort_read_data", {24'b0, read_data}, 32'h0);
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b1;
      unexp0 = unexpected;
      repeat (120) @(negedge clk);
      checkOutput("no_event_after_abort", unexpected - unexp0, 32'd0);

      $display("[TB] write 0x7FC3 with cmd_vld while busy");
      applyStimulus(16'h7FC3, acc);
      checkOutput("cmd_rdy_busy2", {31'b0, cmd_rdy}, 32'd0);
      wait_until(acc + 20);
      cmd_in  = 16'h8A00;
      cmd_vld = 1'b1;
      repeat (5) @(negedge clk);
      cmd_vld = 1'b0;
      wait_idle();
      unexp0 = unexpected;
      repeat (200) @(negedge clk);
      checkOutput("busy_cmd_ignored", unexpected - unexp0, 32'd0);
      checkOutput("idle_tx", {31'b0, tx}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog at cycle %0d: got no completion, want end of test", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
